// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write arbiter and its aux queue.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 64;
  localparam int CNT_W      = 4;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUEUED = 2'd1,
    FORCE  = 2'd2
  } arb_state_t;

  // X31 is hardwired zero: writes to it are dropped and it never raises a hazard.
  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr == ZERO_REG;
  endfunction

endpackage

// File: rtl/warb_fifo.sv
// In-order circular queue of pending aux writes with a per-entry address-match vector.
// Optional youngest-match bypass read when WARB_BYPASS_EN is defined.
module warb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wr_req_t               push_req,
  input  logic                  pop,
  input  logic [REG_ADDR_W-1:0] chk_addr,
  output wr_req_t               head,
  output logic [CNT_W-1:0]      count,
  output logic [DEPTH-1:0]      match_vec
`ifdef WARB_BYPASS_EN
  ,
  output logic                  byp_valid,
  output logic [DATA_W-1:0]     byp_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  wr_req_t          mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic [PW-1:0]    offset_s;

  assign pop_ok_s  = pop && (count_r != 4'd0);
  assign push_ok_s = push && (count_r < DEPTH_C);
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointer and occupancy bookkeeping; simultaneous push and pop keeps count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= 4'd0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 4'd1;
        2'b01:   count_r <= count_r - 4'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_req;
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    match_vec = '0;
    offset_s  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      offset_s = PW'(j) - rd_ptr_r;
      if ((CNT_W'(offset_s) < count_r) && (mem_r[j].addr == chk_addr) && !is_zero_reg(chk_addr)) begin
        match_vec[j] = 1'b1;
      end else begin
        match_vec[j] = 1'b0;
      end
    end
  end

`ifdef WARB_BYPASS_EN
  logic [PW-1:0] idx_s;

  // Walk oldest to youngest so the last live match (the youngest) wins.
  always_comb begin
    byp_valid = 1'b0;
    byp_data  = '0;
    idx_s     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = rd_ptr_r + PW'(i);
      if (match_vec[idx_s]) begin
        byp_valid = 1'b1;
        byp_data  = mem_r[idx_s].data;
      end else begin
        byp_valid = byp_valid;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and a queued aux unit.
// Define WARB_BYPASS_EN to add the byp_valid/byp_data youngest-match forwarding outputs.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  aux_valid,
  input  logic [REG_ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0]     aux_data,
  output logic                  aux_ready,
  output logic                  rf_wr_en,
  output logic [REG_ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0]     rf_wr_data,
  input  logic [REG_ADDR_W-1:0] chk_addr,
  output logic                  chk_pending,
  output logic                  stall_req,
  output logic [CNT_W-1:0]      fifo_count
`ifdef WARB_BYPASS_EN
  ,
  output logic                  byp_valid,
  output logic [DATA_W-1:0]     byp_data
`endif
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [SW-1:0]    LIM_C    = SW'(STARVE_LIM);
  localparam logic [SW-1:0]    LIM_M1_C = SW'(STARVE_LIM - 1);

  arb_state_t            state_r;
  arb_state_t            state_nxt_s;
  logic [SW-1:0]         starve_cnt_r;
  wr_req_t               head_s;
  wr_req_t               push_req_s;
  wr_req_t               grant_req_s;
  logic                  grant_en_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  wb_ok_s;
  logic                  force_s;
  logic [CNT_W-1:0]      count_s;
  logic [DEPTH-1:0]      match_vec_s;
  logic                  rf_wr_en_r;
  logic [REG_ADDR_W-1:0] rf_wr_addr_r;
  logic [DATA_W-1:0]     rf_wr_data_r;

  assign aux_ready   = (count_s < DEPTH_C) && !reset;
  assign push_s      = aux_valid && aux_ready && !is_zero_reg(aux_addr);
  assign push_req_s  = '{addr: aux_addr, data: aux_data};
  assign wb_ok_s     = wb_en && !is_zero_reg(wb_addr);
  assign fifo_count  = count_s;
  assign chk_pending = |match_vec_s;
  assign rf_wr_en    = rf_wr_en_r;
  assign rf_wr_addr  = rf_wr_addr_r;
  assign rf_wr_data  = rf_wr_data_r;

  warb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_req  (push_req_s),
    .pop       (pop_s),
    .chk_addr  (chk_addr),
    .head      (head_s),
    .count     (count_s),
    .match_vec (match_vec_s)
`ifdef WARB_BYPASS_EN
    ,
    .byp_valid (byp_valid),
    .byp_data  (byp_data)
`endif
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // FSM next-state: a starving head escalates to FORCE for a single cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (push_s) state_nxt_s = QUEUED;
        else        state_nxt_s = IDLE;
      end
      QUEUED: begin
        if (pop_s && (count_s == 4'd1) && !push_s)    state_nxt_s = IDLE;
        else if (!pop_s && (starve_cnt_r == LIM_M1_C)) state_nxt_s = FORCE;
        else                                           state_nxt_s = QUEUED;
      end
      FORCE: begin
        if ((count_s == 4'd1) && !push_s) state_nxt_s = IDLE;
        else                              state_nxt_s = QUEUED;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    force_s   = (state_r == FORCE);
    stall_req = force_s;
  end

  // Port grant: forced head, then writeback, then queued head.
  always_comb begin
    pop_s       = 1'b0;
    grant_en_s  = 1'b0;
    grant_req_s = '0;
    if (force_s && (count_s != 4'd0)) begin
      pop_s       = 1'b1;
      grant_en_s  = 1'b1;
      grant_req_s = head_s;
    end else if (!force_s && wb_ok_s) begin
      grant_en_s  = 1'b1;
      grant_req_s = '{addr: wb_addr, data: wb_data};
    end else if (count_s != 4'd0) begin
      pop_s       = 1'b1;
      grant_en_s  = 1'b1;
      grant_req_s = head_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Head wait counter: counts unserved QUEUED cycles, cleared by any pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= '0;
    end else if (pop_s) begin
      starve_cnt_r <= '0;
    end else if ((state_r == QUEUED) && (starve_cnt_r != LIM_C)) begin
      starve_cnt_r <= starve_cnt_r + SW'(1);
    end
  end

  // Registered write port; a reset edge cancels whatever was granted that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wr_en_r   <= 1'b0;
      rf_wr_addr_r <= '0;
      rf_wr_data_r <= '0;
    end else begin
      rf_wr_en_r   <= grant_en_s;
      rf_wr_addr_r <= grant_req_s.addr;
      rf_wr_data_r <= grant_req_s.data;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (default DEPTH=4, STARVE_LIM=8).
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        aux_valid;
  logic [4:0]  aux_addr;
  logic [63:0] aux_data;
  logic        aux_ready;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [63:0] rf_wr_data;
  logic [4:0]  chk_addr;
  logic        chk_pending;
  logic        stall_req;
  logic [3:0]  fifo_count;
`ifdef WARB_BYPASS_EN
  logic        byp_valid;
  logic [63:0] byp_data;
`endif

  int check_cnt;
  int error_cnt;

  regfile_write_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .aux_valid   (aux_valid),
    .aux_addr    (aux_addr),
    .aux_data    (aux_data),
    .aux_ready   (aux_ready),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .chk_addr    (chk_addr),
    .chk_pending (chk_pending),
    .stall_req   (stall_req),
    .fifo_count  (fifo_count)
`ifdef WARB_BYPASS_EN
    ,
    .byp_valid   (byp_valid),
    .byp_data    (byp_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      error_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected write-port contents one cycle after a grant.
  task automatic check_wr(input string tag, input logic en, input logic [4:0] addr, input logic [63:0] data);
    check_eq({tag, "_en"}, 64'(rf_wr_en), 64'(en));
    if (en) begin
      check_eq({tag, "_addr"}, 64'(rf_wr_addr), 64'(addr));
      check_eq({tag, "_data"}, rf_wr_data, data);
    end
  endtask

  initial begin
    check_cnt = 0;
    error_cnt = 0;
    reset = 1'b1; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 64'd0;
    aux_valid = 1'b0; aux_addr = 5'd0; aux_data = 64'd0; chk_addr = 5'd0;
    tick();
    tick();
    check_wr("rst", 1'b0, 5'd0, 64'd0);
    check_eq("rst_addr", 64'(rf_wr_addr), 64'd0);
    check_eq("rst_data", rf_wr_data, 64'd0);
    check_eq("rst_stall", 64'(stall_req), 64'd0);
    check_eq("rst_count", 64'(fifo_count), 64'd0);
    check_eq("rst_ready_in_reset", 64'(aux_ready), 64'd0);
    reset = 1'b0;
    #1;
    check_eq("rst_ready_after", 64'(aux_ready), 64'd1);

    // Priority: WB X5 and aux X6 in the same cycle.
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'hAA;
    aux_valid = 1'b1; aux_addr = 5'd6; aux_data = 64'hBB;
    #1;
    check_eq("prio_ready", 64'(aux_ready), 64'd1);
    tick();
    wb_en = 1'b0; aux_valid = 1'b0;
    check_wr("prio_t1", 1'b1, 5'd5, 64'hAA);
    check_eq("prio_cnt1", 64'(fifo_count), 64'd1);
    tick();
    check_wr("prio_t2", 1'b1, 5'd6, 64'hBB);
    check_eq("prio_cnt2", 64'(fifo_count), 64'd0);
    tick();
    check_wr("prio_t3", 1'b0, 5'd0, 64'd0);

    // Zero register: aux and WB writes to X31 vanish.
    aux_valid = 1'b1; aux_addr = 5'd31; aux_data = 64'h55;
    #1;
    check_eq("zero_ready", 64'(aux_ready), 64'd1);
    tick();
    aux_valid = 1'b0;
    check_eq("zero_cnt", 64'(fifo_count), 64'd0);
    check_wr("zero_aux", 1'b0, 5'd0, 64'd0);
    wb_en = 1'b1; wb_addr = 5'd31; wb_data = 64'h66;
    tick();
    wb_en = 1'b0;
    check_wr("zero_wb", 1'b0, 5'd0, 64'd0);

    // Hazard: two queued writes to X7 behind a busy WB.
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 64'h11;
    aux_valid = 1'b1; aux_addr = 5'd7; aux_data = 64'h1;
    tick();
    aux_data = 64'h2;
    tick();
    wb_en = 1'b0; aux_valid = 1'b0;
    check_wr("haz_wb", 1'b1, 5'd1, 64'h11);
    check_eq("haz_cnt", 64'(fifo_count), 64'd2);
    chk_addr = 5'd7;
    #1;
    check_eq("haz_pend7", 64'(chk_pending), 64'd1);
`ifdef WARB_BYPASS_EN
    check_eq("haz_byp_valid", 64'(byp_valid), 64'd1);
    check_eq("haz_byp_data", byp_data, 64'h2);
`endif
    chk_addr = 5'd31;
    #1;
    check_eq("haz_pend31", 64'(chk_pending), 64'd0);
    chk_addr = 5'd8;
    #1;
    check_eq("haz_pend8", 64'(chk_pending), 64'd0);
    tick();
    check_wr("haz_pop1", 1'b1, 5'd7, 64'h1);
    tick();
    check_wr("haz_pop2", 1'b1, 5'd7, 64'h2);
    check_eq("haz_cnt0", 64'(fifo_count), 64'd0);

    // Simultaneous push and pop at count 2.
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 64'h11;
    aux_valid = 1'b1; aux_addr = 5'd10; aux_data = 64'hA0;
    tick();
    aux_addr = 5'd11; aux_data = 64'hA1;
    tick();
    check_eq("pp_cnt_pre", 64'(fifo_count), 64'd2);
    wb_en = 1'b0; aux_addr = 5'd12; aux_data = 64'hA2;
    tick();
    aux_valid = 1'b0;
    check_eq("pp_cnt_same", 64'(fifo_count), 64'd2);
    check_wr("pp_pop10", 1'b1, 5'd10, 64'hA0);
    tick();
    check_wr("pp_pop11", 1'b1, 5'd11, 64'hA1);
    tick();
    check_wr("pp_pop12", 1'b1, 5'd12, 64'hA2);
    check_eq("pp_cnt0", 64'(fifo_count), 64'd0);
    tick();
    check_wr("pp_idle", 1'b0, 5'd0, 64'd0);

    // Full queue with WB held high: head forced after 8 waiting cycles.
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 64'h22;
    aux_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      aux_addr = 5'(20 + k);
      aux_data = 64'hC0 + 64'(k);
      tick();
    end
    aux_valid = 1'b0;
    check_eq("full_cnt", 64'(fifo_count), 64'd4);
    check_eq("full_ready", 64'(aux_ready), 64'd0);
    check_eq("full_stall0", 64'(stall_req), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
    end
    check_eq("starve_stall7", 64'(stall_req), 64'd0);
    check_wr("starve_wb7", 1'b1, 5'd2, 64'h22);
    tick();
    check_eq("starve_stall8", 64'(stall_req), 64'd1);
    tick();
    check_eq("starve_stall9", 64'(stall_req), 64'd0);
    check_wr("starve_head", 1'b1, 5'd20, 64'hC0);
    check_eq("starve_ready", 64'(aux_ready), 64'd1);
    check_eq("starve_cnt3", 64'(fifo_count), 64'd3);
    wb_en = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      check_wr("drain", 1'b1, 5'(20 + k), 64'hC0 + 64'(k));
    end
    check_eq("drain_cnt0", 64'(fifo_count), 64'd0);

    // Reset mid-queue with 3 entries and a WB grant in flight.
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 64'h11;
    aux_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      aux_addr = 5'(3 + k);
      aux_data = 64'hD0 + 64'(k);
      tick();
    end
    aux_valid = 1'b0;
    check_eq("mid_cnt3", 64'(fifo_count), 64'd3);
    wb_addr = 5'd9; wb_data = 64'h99;
    reset = 1'b1;
    #1;
    check_eq("mid_ready_rst", 64'(aux_ready), 64'd0);
    tick();
    wb_en = 1'b0;
    check_eq("mid_cnt0", 64'(fifo_count), 64'd0);
    check_wr("mid_wr", 1'b0, 5'd0, 64'd0);
    check_eq("mid_stall", 64'(stall_req), 64'd0);
    reset = 1'b0;
    #1;
    check_eq("mid_ready_after", 64'(aux_ready), 64'd1);
    tick();
    check_wr("mid_no_pulse", 1'b0, 5'd0, 64'd0);
    check_eq("mid_cnt_after", 64'(fifo_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end

endmodule
